// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: the decoded control bundle, ALUOp encodings and opcodes.
package mips_pkg;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that increments on request, holds otherwise and sticks at 0xFFFF.
module sat_counter16
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with stall, load-use bubble and branch flush.
// Define ID_EX_PERF_EN to add the saturating perf_bubbles / perf_flushes counters.
module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [1:0]    id_aluop,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_branch,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_regwrite,
  input  logic          id_memtoreg,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          hazard_detected,
  input  logic          stall,
  input  logic          flush,
  output logic          ex_valid,
  output logic [1:0]    ex_aluop,
  output logic          ex_alusrc,
  output logic          ex_regdst,
  output logic          ex_branch,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [RW-1:0] ex_load_rt
`ifdef ID_EX_PERF_EN
  ,
  output logic [15:0]   perf_bubbles,
  output logic [15:0]   perf_flushes
`endif
);

  ctrl_t         id_ctrl;
  ctrl_t         ctrl_q,   ctrl_d;
  logic          valid_q,  valid_d;
  logic [DW-1:0] pc4_q,    pc4_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [DW-1:0] rdata2_q, rdata2_d;
  logic [DW-1:0] imm_q,    imm_d;
  logic [RW-1:0] rs_q,     rs_d;
  logic [RW-1:0] rt_q,     rt_d;
  logic [RW-1:0] rd_q,     rd_d;

  assign id_ctrl = {id_aluop, id_alusrc, id_regdst, id_branch,
                    id_memread, id_memwrite, id_regwrite, id_memtoreg};

  // Squashes (flush or bubble) empty the slot but leave the data fields untouched.
  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    pc4_d    = pc4_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (hazard_detected) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else begin
      valid_d  = id_valid;
      ctrl_d   = id_valid ? id_ctrl : CTRL_NOP;
      pc4_d    = id_pc4;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      ctrl_q   <= CTRL_NOP;
      pc4_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      pc4_q    <= pc4_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_regdst   = ctrl_q.regdst;
  assign ex_branch   = ctrl_q.branch;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_pc4      = pc4_q;
  assign ex_rdata1   = rdata1_q;
  assign ex_rdata2   = rdata2_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign ex_load_rt  = (valid_q && ctrl_q.memread) ? rt_q : '0;

`ifdef ID_EX_PERF_EN
  logic bubble_edge;

  // A bubble only counts on edges where it actually takes effect.
  assign bubble_edge = hazard_detected && !flush && !stall;

  sat_counter16 u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_edge),
    .count (perf_bubbles)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: stimulus pushes hand-derived expected EX snapshots, a monitor pops and compares.
module tb_id_ex_pipe;
  import mips_pkg::*;

  typedef enum logic [2:0] {A_LOAD, A_HOLD, A_BUBBLE, A_FLUSH, A_RESET} act_e;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] pc4;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } in_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] pc4;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  load_rt;
    logic [15:0] bubbles;
    logic [15:0] flushes;
  } out_t;

  localparam ctrl_t C_LW    = '{aluop: ALUOP_ADD, alusrc: 1'b1, regdst: 1'b0, branch: 1'b0,
                                memread: 1'b1, memwrite: 1'b0, regwrite: 1'b1, memtoreg: 1'b1};
  localparam ctrl_t C_SW    = '{aluop: ALUOP_ADD, alusrc: 1'b1, regdst: 1'b0, branch: 1'b0,
                                memread: 1'b0, memwrite: 1'b1, regwrite: 1'b0, memtoreg: 1'b0};
  localparam ctrl_t C_BEQ   = '{aluop: ALUOP_SUB, alusrc: 1'b0, regdst: 1'b0, branch: 1'b1,
                                memread: 1'b0, memwrite: 1'b0, regwrite: 1'b0, memtoreg: 1'b0};
  localparam ctrl_t C_RTYPE = '{aluop: ALUOP_RTYPE, alusrc: 1'b0, regdst: 1'b1, branch: 1'b0,
                                memread: 1'b0, memwrite: 1'b0, regwrite: 1'b1, memtoreg: 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_aluop;
  logic        id_alusrc, id_regdst, id_branch, id_memread, id_memwrite, id_regwrite, id_memtoreg;
  logic [31:0] id_pc4, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        hazard_detected, stall, flush;
  logic        ex_valid;
  logic [1:0]  ex_aluop;
  logic        ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [31:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_load_rt;
`ifdef ID_EX_PERF_EN
  logic [15:0] perf_bubbles, perf_flushes;
`endif

  always #5 clk = ~clk;

  id_ex_pipe #(.DW(32), .RW(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_aluop        (id_aluop),
    .id_alusrc       (id_alusrc),
    .id_regdst       (id_regdst),
    .id_branch       (id_branch),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .id_regwrite     (id_regwrite),
    .id_memtoreg     (id_memtoreg),
    .id_pc4          (id_pc4),
    .id_rdata1       (id_rdata1),
    .id_rdata2       (id_rdata2),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .hazard_detected (hazard_detected),
    .stall           (stall),
    .flush           (flush),
    .ex_valid        (ex_valid),
    .ex_aluop        (ex_aluop),
    .ex_alusrc       (ex_alusrc),
    .ex_regdst       (ex_regdst),
    .ex_branch       (ex_branch),
    .ex_memread      (ex_memread),
    .ex_memwrite     (ex_memwrite),
    .ex_regwrite     (ex_regwrite),
    .ex_memtoreg     (ex_memtoreg),
    .ex_pc4          (ex_pc4),
    .ex_rdata1       (ex_rdata1),
    .ex_rdata2       (ex_rdata2),
    .ex_imm          (ex_imm),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_load_rt      (ex_load_rt)
`ifdef ID_EX_PERF_EN
    ,
    .perf_bubbles    (perf_bubbles),
    .perf_flushes    (perf_flushes)
`endif
  );

  out_t exp_q[$];
  int   step_q[$];
  out_t model;
  int   step_no;
  int   n_checks;
  int   n_pass;
  event check_ev;

  function automatic in_t mk(input logic v, input ctrl_t c, input logic [31:0] pc4,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    in_t x;
    x.valid = v; x.ctrl = c; x.pc4 = pc4; x.rdata1 = r1; x.rdata2 = r2;
    x.imm = imm; x.rs = rs; x.rt = rt; x.rd = rd;
    return x;
  endfunction

  task automatic updateModel(input act_e act, input in_t v);
    case (act)
      A_LOAD: begin
        model.valid  = v.valid;
        model.ctrl   = v.valid ? v.ctrl : CTRL_NOP;
        model.pc4    = v.pc4;
        model.rdata1 = v.rdata1;
        model.rdata2 = v.rdata2;
        model.imm    = v.imm;
        model.rs     = v.rs;
        model.rt     = v.rt;
        model.rd     = v.rd;
      end
      A_BUBBLE: begin
        model.valid = 1'b0;
        model.ctrl  = CTRL_NOP;
        if (model.bubbles != 16'hFFFF) model.bubbles = model.bubbles + 16'd1;
      end
      A_FLUSH: begin
        model.valid = 1'b0;
        model.ctrl  = CTRL_NOP;
        if (model.flushes != 16'hFFFF) model.flushes = model.flushes + 16'd1;
      end
      A_RESET: model = '0;
      default: ;
    endcase
    model.load_rt = (model.valid && model.ctrl.memread) ? model.rt : 5'd0;
  endtask

  task automatic pushExpected();
    step_no = step_no + 1;
    exp_q.push_back(model);
    step_q.push_back(step_no);
  endtask

  task automatic applyStimulus(input in_t v, input logic hz, input logic st, input logic fl,
                               input act_e act);
    id_valid    = v.valid;
    id_aluop    = v.ctrl.aluop;
    id_alusrc   = v.ctrl.alusrc;
    id_regdst   = v.ctrl.regdst;
    id_branch   = v.ctrl.branch;
    id_memread  = v.ctrl.memread;
    id_memwrite = v.ctrl.memwrite;
    id_regwrite = v.ctrl.regwrite;
    id_memtoreg = v.ctrl.memtoreg;
    id_pc4      = v.pc4;
    id_rdata1   = v.rdata1;
    id_rdata2   = v.rdata2;
    id_imm      = v.imm;
    id_rs       = v.rs;
    id_rt       = v.rt;
    id_rd       = v.rd;
    hazard_detected = hz;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    #1;
    updateModel(act, v);
    pushExpected();
  endtask

  task automatic checkOutput();
    out_t exp_o;
    out_t act_o;
    int   s;
    exp_o = exp_q.pop_front();
    s     = step_q.pop_front();
    act_o.valid  = ex_valid;
    act_o.ctrl   = {ex_aluop, ex_alusrc, ex_regdst, ex_branch,
                    ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg};
    act_o.pc4    = ex_pc4;
    act_o.rdata1 = ex_rdata1;
    act_o.rdata2 = ex_rdata2;
    act_o.imm    = ex_imm;
    act_o.rs     = ex_rs;
    act_o.rt     = ex_rt;
    act_o.rd     = ex_rd;
    act_o.load_rt = ex_load_rt;
`ifdef ID_EX_PERF_EN
    act_o.bubbles = perf_bubbles;
    act_o.flushes = perf_flushes;
`else
    act_o.bubbles = 16'd0;
    act_o.flushes = 16'd0;
    exp_o.bubbles = 16'd0;
    exp_o.flushes = 16'd0;
`endif
    n_checks = n_checks + 1;
    if (act_o === exp_o) begin
      n_pass = n_pass + 1;
    end else begin
      $display("[TB] FAIL step %0d ex_snapshot: got %h want %h", s, act_o, exp_o);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or check_ev);
      if (exp_q.size() > 0) checkOutput();
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_t idle, lw5, rtype_a, nop_in, sw_b, beq_c, lw9, rtype_d, junk;
    n_checks = 0;
    n_pass   = 0;
    step_no  = 0;
    model    = '0;
    idle    = mk(1'b0, CTRL_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    lw5     = mk(1'b1, C_LW,    32'h0000_0104, 32'h0000_1000, 32'h1111_2222, 32'h0000_0010, 5'd3, 5'd5, 5'd0);
    rtype_a = mk(1'b1, C_RTYPE, 32'h0000_0108, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_2020, 5'd7, 5'd8, 5'd9);
    nop_in  = mk(1'b0, C_LW,    32'h0000_010C, 32'h0000_00C1, 32'h0000_00C2, 32'hFFFF_FFF0, 5'd10, 5'd11, 5'd12);
    sw_b    = mk(1'b1, C_SW,    32'h0000_0110, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_0004, 5'd13, 5'd14, 5'd0);
    beq_c   = mk(1'b1, C_BEQ,   32'h0000_0114, 32'h0000_0042, 32'h0000_0042, 32'hFFFF_FFFC, 5'd15, 5'd16, 5'd0);
    lw9     = mk(1'b1, C_LW,    32'h0000_0200, 32'h0000_3000, 32'h0, 32'h0000_0008, 5'd4, 5'd9, 5'd0);
    rtype_d = mk(1'b1, C_RTYPE, 32'h0000_0300, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0820, 5'd1, 5'd2, 5'd3);
    junk    = mk(1'b1, C_RTYPE, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888, 5'd21, 5'd22, 5'd23);

    reset = 1'b1;
    hazard_detected = 1'b0; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_aluop = 2'b00; id_alusrc = 1'b0; id_regdst = 1'b0; id_branch = 1'b0;
    id_memread = 1'b0; id_memwrite = 1'b0; id_regwrite = 1'b0; id_memtoreg = 1'b0;
    id_pc4 = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    #2;
    updateModel(A_RESET, idle);
    pushExpected();
    ->check_ev;
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(lw5,     1'b0, 1'b0, 1'b0, A_LOAD);
    applyStimulus(rtype_a, 1'b1, 1'b0, 1'b0, A_BUBBLE);
    applyStimulus(rtype_a, 1'b0, 1'b0, 1'b0, A_LOAD);
    applyStimulus(nop_in,  1'b0, 1'b0, 1'b0, A_LOAD);
    applyStimulus(sw_b,    1'b0, 1'b0, 1'b0, A_LOAD);
    applyStimulus(junk,    1'b0, 1'b1, 1'b0, A_HOLD);
    applyStimulus(junk,    1'b1, 1'b1, 1'b0, A_HOLD);
    applyStimulus(junk,    1'b0, 1'b1, 1'b0, A_HOLD);
    applyStimulus(beq_c,   1'b0, 1'b0, 1'b0, A_LOAD);
    applyStimulus(junk,    1'b0, 1'b1, 1'b1, A_FLUSH);
    applyStimulus(lw9,     1'b0, 1'b0, 1'b0, A_LOAD);
    applyStimulus(junk,    1'b1, 1'b0, 1'b1, A_FLUSH);
    applyStimulus(rtype_d, 1'b0, 1'b0, 1'b0, A_LOAD);

    // Mid-cycle reset while an R-type is held: outputs must clear before the next edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    updateModel(A_RESET, idle);
    pushExpected();
    ->check_ev;
    applyStimulus(junk,    1'b1, 1'b0, 1'b1, A_RESET);
    reset = 1'b0;
    applyStimulus(lw5,     1'b0, 1'b0, 1'b0, A_LOAD);
    applyStimulus(rtype_a, 1'b1, 1'b0, 1'b0, A_BUBBLE);

`ifdef ID_EX_PERF_EN
    for (int i = 0; i < 65537; i++) begin
      applyStimulus(junk, 1'b1, 1'b0, 1'b0, A_BUBBLE);
    end
    applyStimulus(junk, 1'b1, 1'b1, 1'b0, A_HOLD);
`endif

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks = n_checks + 1;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Pipeline register between the decode stage and the execute stage of the 5-stage MIPS core. It captures the decoded control bundle (ALUOp, ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg) together with the register operands, sign-extended immediate, PC+4 and register specifiers, and presents them to EX one cycle later. It implements hold (stall), bubble insertion on load-use hazards, and flush on taken branch. It also exposes the EX-stage load destination that the hazard detector needs.

## Interface
- DW, default 32: datapath width (PC, operands, immediate).
- RW, default 5: register-specifier width.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_valid  in  1  ID holds a real instruction this cycle.
- id_aluop  in  2  ALUOp from Control.
- id_alusrc, id_regdst, id_branch, id_memread, id_memwrite, id_regwrite, id_memtoreg  in  1 each  Control outputs.
- id_pc4  in  DW  PC+4 of the ID instruction.
- id_rdata1, id_rdata2  in  DW  register-file read data.
- id_imm  in  DW  sign-extended immediate.
- id_rs, id_rt, id_rd  in  RW  register specifiers.
- hazard_detected  in  1  load-use hazard; insert a bubble into EX.
- stall  in  1  downstream hold; register keeps its contents.
- flush  in  1  taken branch resolved; squash the EX-bound instruction.
- ex_valid  out  1  EX holds a real instruction.
- ex_aluop  out  2; ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg  out  1 each  registered control.
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  out  DW  registered data.
- ex_rs, ex_rt, ex_rd  out  RW  registered specifiers.
- ex_load_rt  out  RW  equals ex_rt when ex_memread is 1 and ex_valid is 1, otherwise 0. Feeds the hazard detector.

## Operation
- Each edge performs exactly one action, chosen by this priority: reset, then flush, then stall, then hazard_detected, then load.
- Flush: ex_valid and all control outputs go to 0. Datapath and specifier fields hold their previous values.
- Stall (no flush): every register holds. A bubble requested during a stall is dropped. The upstream hazard logic re-asserts it after the stall ends.
- Bubble (hazard_detected, no flush, no stall): same effect as flush.
- Load: when id_valid is 1, capture all inputs and set ex_valid to 1. When id_valid is 0, clear the control outputs and ex_valid but still capture the data fields.
- The control outputs of an invalid slot are always 0. RegWrite, MemWrite and Branch therefore never fire for a bubble.
- Reset values: every output is 0, including the counters.

## Timing
- Latency is 1 cycle from ID inputs to EX outputs. There is no combinational path from input to output except the derivation of ex_load_rt from registered state.
- Reset acts immediately and asynchronously. Outputs are 0 before the next edge. The first capture happens on the first rising edge after reset is deasserted.
- Reset in the middle of a stall discards the held instruction. Reset in the same cycle as a flush or bubble still gives all zeros.
- flush and stall asserted together: flush wins and the slot becomes empty on that edge.

## Configuration
- ID_EX_PERF_EN defined: the block adds two 16-bit outputs.
  - perf_bubbles: incremented on each bubble edge.
  - perf_flushes: incremented on each flush edge.
  - Both counters saturate at 0xFFFF and do not wrap.
  - Both are cleared by reset.
  - Both hold during stall.
- ID_EX_PERF_EN undefined: these ports and their logic do not exist, and behaviour is otherwise identical.

## Structure
- Shared package mips_pkg holds the following:
  - the packed ctrl_t struct containing aluop[1:0], alusrc, regdst, branch, memread, memwrite, regwrite and memtoreg;
  - the CTRL_NOP constant (all zeros);
  - the ALUOP_ADD (00), ALUOP_SUB (01) and ALUOP_RTYPE (10) constants;
  - the opcode constants OP_LW, OP_SW, OP_BEQ and OP_RTYPE.
- One sub-module, sat_counter16, provides the counter with increment, hold and saturate behaviour. It is instantiated twice under ID_EX_PERF_EN.

## Test plan
- LW (opcode 100011) with rt=5 and id_valid=1 → the next cycle shows ex_memread=1, ex_memtoreg=1, ex_alusrc=1, ex_regwrite=1, ex_rt=5 and ex_load_rt=5.
- hazard_detected=1 with an R-type on the inputs → the next cycle shows ex_valid=0, all control outputs 0, ex_load_rt=0, and perf_bubbles=1 when ID_EX_PERF_EN is defined.
- Stall for 3 cycles while holding an SW with rdata2=0xDEADBEEF → the outputs stay unchanged for all 3 cycles, and a hazard_detected pulse applied during the stall has no effect.
- flush and stall asserted together while EX holds a BEQ → the next cycle shows ex_valid=0 and ex_branch=0, and perf_flushes increments.
- reset asserted in the middle of a cycle while an R-type is held → all outputs read 0 before the next edge, and the counters read 0.
- Under ID_EX_PERF_EN, apply 65,537 bubbles → perf_bubbles reads 0xFFFF and does not wrap.
